// File: rtl/rsa_decryption.sv
// RSA decryption engine: publishes a fixed key pair on request and computes
// M = C^D mod N with LSB-first square-and-multiply, using two bit-serial
// interleaved modular multipliers that run in lock-step.
module rsa_decryption #(
    parameter int                   WIDTH = 512,
    parameter logic [4*WIDTH-1:0]   KEY_N = (4*WIDTH)'(3233),
    parameter logic [WIDTH-1:0]     KEY_E = WIDTH'(17),
    parameter logic [4*WIDTH-1:0]   KEY_D = (4*WIDTH)'(2753)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    In_Data_Ready,
    input  logic [4*WIDTH-1:0]      In_Data_word,
    input  logic                    New_RSA_Start,
    output logic [WIDTH-1:0]        Out_publicKey_exp,
    output logic [4*WIDTH-1:0]      Out_publicKey_mod,
    output logic                    ready_to_encryption,
    output logic [4*WIDTH-1:0]      Out_Data_word,
    output logic                    Decrypt_done
);

    localparam int              DW   = 4 * WIDTH;
    localparam int              CW   = $clog2(DW);
    localparam logic [CW-1:0]   LAST = CW'(DW - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KEYLOAD  = 3'd1,
        READY    = 3'd2,
        BUSY     = 3'd3,
        DONE     = 3'd4,
        WAIT_LOW = 3'd5
    } state_t;

    // One interleaved step: acc = (2*acc + a_bit*b) mod N. With acc, b < N
    // the sum stays below 3N, so two conditional subtractions suffice.
    function automatic logic [DW-1:0] mod_mul_step(input logic [DW-1:0] acc,
                                                   input logic          a_bit,
                                                   input logic [DW-1:0] b);
        logic [DW+1:0] t;
        t = {1'b0, acc, 1'b0} + (a_bit ? {2'b00, b} : {(DW+2){1'b0}});
        if (t >= {2'b00, KEY_N}) t = t - {2'b00, KEY_N};
        if (t >= {2'b00, KEY_N}) t = t - {2'b00, KEY_N};
        return t[DW-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  exp_q, exp_d;
    logic [DW-1:0]     mod_q, mod_d;
    logic [DW-1:0]     data_q, data_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic [DW-1:0]     res_q, res_d;       // running result
    logic [DW-1:0]     base_q, base_d;     // running base
    logic [DW-1:0]     pr_q, pr_d;         // partial product result*base
    logic [DW-1:0]     pb_q, pb_d;         // partial product base*base
    logic [CW-1:0]     mul_cnt_q, mul_cnt_d;
    logic [CW-1:0]     bit_idx_q, bit_idx_d;

    logic [CW-1:0]     idx_s;
    logic              d_bit_s;
    logic [DW-1:0]     pr_next_s, pb_next_s, res_next_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        mod_d      = mod_q;
        data_d     = data_q;
        res_d      = res_q;
        base_d     = base_q;
        pr_d       = pr_q;
        pb_d       = pb_q;
        mul_cnt_d  = mul_cnt_q;
        bit_idx_d  = bit_idx_q;
        // Multiplier bits are consumed MSB-first.
        idx_s      = LAST - mul_cnt_q;
        d_bit_s    = KEY_D[bit_idx_q];
        pr_next_s  = mod_mul_step(pr_q, res_q[idx_s], base_q);
        pb_next_s  = mod_mul_step(pb_q, base_q[idx_s], base_q);
        res_next_s = d_bit_s ? pr_next_s : res_q;

        case (state_q)
            IDLE: begin
                if (New_RSA_Start) state_d = KEYLOAD;
                else               state_d = IDLE;
            end
            KEYLOAD: begin
                exp_d   = KEY_E;
                mod_d   = KEY_N;
                state_d = READY;
            end
            READY: begin
                if (New_RSA_Start) begin
                    state_d = KEYLOAD;
                end else if (In_Data_Ready) begin
                    if (In_Data_word >= KEY_N) begin
                        // Out-of-range ciphertext: no exponentiation.
                        data_d  = {DW{1'b0}};
                        state_d = DONE;
                    end else begin
                        base_d    = In_Data_word;
                        res_d     = {{(DW-1){1'b0}}, 1'b1};
                        pr_d      = {DW{1'b0}};
                        pb_d      = {DW{1'b0}};
                        mul_cnt_d = {CW{1'b0}};
                        bit_idx_d = {CW{1'b0}};
                        state_d   = BUSY;
                    end
                end else begin
                    state_d = READY;
                end
            end
            BUSY: begin
                if (mul_cnt_q == LAST) begin
                    // Both multiplies complete: commit the exponent step.
                    // The result product is always computed so latency
                    // does not depend on D.
                    res_d     = res_next_s;
                    base_d    = pb_next_s;
                    pr_d      = {DW{1'b0}};
                    pb_d      = {DW{1'b0}};
                    mul_cnt_d = {CW{1'b0}};
                    if (bit_idx_q == LAST) begin
                        data_d  = res_next_s;
                        state_d = DONE;
                    end else begin
                        bit_idx_d = bit_idx_q + CW'(1);
                        state_d   = BUSY;
                    end
                end else begin
                    pr_d      = pr_next_s;
                    pb_d      = pb_next_s;
                    mul_cnt_d = mul_cnt_q + CW'(1);
                    state_d   = BUSY;
                end
            end
            DONE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!In_Data_Ready) state_d = READY;
                else                state_d = WAIT_LOW;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        done_d = (state_d == DONE);
        rdy_d  = (state_d == READY) || (state_d == BUSY) ||
                 (state_d == DONE)  || (state_d == WAIT_LOW);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            state_q   <= IDLE;
            exp_q     <= {WIDTH{1'b0}};
            mod_q     <= {DW{1'b0}};
            data_q    <= {DW{1'b0}};
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
            res_q     <= {DW{1'b0}};
            base_q    <= {DW{1'b0}};
            pr_q      <= {DW{1'b0}};
            pb_q      <= {DW{1'b0}};
            mul_cnt_q <= {CW{1'b0}};
            bit_idx_q <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            mod_q     <= mod_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
            res_q     <= res_d;
            base_q    <= base_d;
            pr_q      <= pr_d;
            pb_q      <= pb_d;
            mul_cnt_q <= mul_cnt_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    assign Out_publicKey_exp   = exp_q;
    assign Out_publicKey_mod   = mod_q;
    assign Out_Data_word       = data_q;
    assign ready_to_encryption = rdy_q;
    assign Decrypt_done        = done_q;

endmodule

// File: tb/tb_rsa_decryption.sv
// Self-checking bench for rsa_decryption with the textbook key
// (N = 3233, E = 17, D = 2753) on a small WIDTH to keep runs short.
module tb_rsa_decryption;

    localparam int WIDTH = 8;
    localparam int DW    = 4 * WIDTH;
    localparam longint unsigned NK = 3233;
    localparam longint unsigned EK = 17;
    localparam longint unsigned DK = 2753;
    localparam int BOUND = DW * (DW + 2) + 4;

    logic              aclk = 1'b0;
    logic              aresetn = 1'b1;
    logic              In_Data_Ready = 1'b0;
    logic [DW-1:0]     In_Data_word = '0;
    logic              New_RSA_Start = 1'b0;
    logic [WIDTH-1:0]  Out_publicKey_exp;
    logic [DW-1:0]     Out_publicKey_mod;
    logic              ready_to_encryption;
    logic [DW-1:0]     Out_Data_word;
    logic              Decrypt_done;

    rsa_decryption #(
        .WIDTH(WIDTH),
        .KEY_N(DW'(NK)),
        .KEY_E(WIDTH'(EK)),
        .KEY_D(DW'(DK))
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .In_Data_Ready(In_Data_Ready),
        .In_Data_word(In_Data_word),
        .New_RSA_Start(New_RSA_Start),
        .Out_publicKey_exp(Out_publicKey_exp),
        .Out_publicKey_mod(Out_publicKey_mod),
        .ready_to_encryption(ready_to_encryption),
        .Out_Data_word(Out_Data_word),
        .Decrypt_done(Decrypt_done)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;
    int lat_ref = -1;

    typedef struct {
        logic [DW-1:0] c;
        logic [DW-1:0] m;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Plain square-and-multiply reference.
    function automatic longint unsigned ref_pow(longint unsigned b, longint unsigned e, longint unsigned n);
        longint unsigned r;
        r = 1 % n;
        b = b % n;
        while (e != 0) begin
            if (e[0]) r = (r * b) % n;
            b = (b * b) % n;
            e = e >> 1;
        end
        return r;
    endfunction

    function automatic longint unsigned ref_dec(longint unsigned c);
        if (c >= NK) return 0;
        return ref_pow(c, DK, NK);
    endfunction

    // Apply one request; lat counts rising edges after the capture edge until
    // Decrypt_done is seen (-1 on timeout). Request is held hold_extra cycles
    // past the done pulse; pulses counts every Decrypt_done observed.
    task automatic run_dec(input logic [DW-1:0] c, input int hold_extra,
                           output logic [DW-1:0] m, output int lat, output int pulses);
        @(negedge aclk);
        In_Data_word  = c;
        In_Data_Ready = 1'b1;
        @(posedge aclk);
        #1;
        In_Data_word = ~c;
        lat = -1;
        pulses = 0;
        m = '0;
        if (Decrypt_done) begin
            lat = 0; m = Out_Data_word; pulses = 1;
        end
        for (int i = 1; i <= BOUND + 4 && lat < 0; i++) begin
            @(posedge aclk); #1;
            if (Decrypt_done) begin
                lat = i; m = Out_Data_word; pulses++;
            end
        end
        for (int i = 0; i < hold_extra; i++) begin
            @(posedge aclk); #1;
            if (Decrypt_done) pulses++;
        end
        @(negedge aclk);
        In_Data_Ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge aclk); #1;
            if (Decrypt_done) pulses++;
        end
    endtask

    // Run a request and check value, pulse count, latency and hold behaviour.
    task automatic do_vec(input string name, input logic [DW-1:0] c, input logic [DW-1:0] m_req, input int hold_extra);
        logic [DW-1:0] m;
        int lat, pulses;
        run_dec(c, hold_extra, m, lat, pulses);
        check({name, ".data"}, m, m_req);
        check({name, ".pulses"}, pulses, 1);
        check({name, ".hold"}, Out_Data_word, m_req);
        if (c >= NK) begin
            check({name, ".lat_skip"}, lat, 0);
        end else begin
            check({name, ".lat_bound"}, (lat >= 0 && lat <= BOUND) ? 1 : 0, 1);
            if (lat_ref < 0) lat_ref = lat;
            else check({name, ".lat_const"}, lat, lat_ref);
        end
    endtask

    task automatic key_load();
        @(negedge aclk); New_RSA_Start = 1'b1;
        @(posedge aclk);
        @(negedge aclk); New_RSA_Start = 1'b0;
        @(posedge aclk); #1;
    endtask

    initial begin
        logic [DW-1:0] c, m;
        int lat1, lat2, pulses;
        int extra;
        longint unsigned c101;

        vecs[0] = '{c: DW'(2790), m: DW'(65)};
        vecs[1] = '{c: DW'(855),  m: DW'(123)};
        vecs[2] = '{c: DW'(0),    m: DW'(0)};
        vecs[3] = '{c: DW'(1),    m: DW'(1)};
        vecs[4] = '{c: DW'(3232), m: DW'(3232)};
        vecs[5] = '{c: DW'(3233), m: DW'(0)};
        vecs[6] = '{c: DW'(4000), m: DW'(0)};

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst.exp", Out_publicKey_exp, 0);
        check("rst.mod", Out_publicKey_mod, 0);
        check("rst.data", Out_Data_word, 0);
        check("rst.rdy", ready_to_encryption, 0);
        check("rst.done", Decrypt_done, 0);
        @(negedge aclk); aresetn = 1'b0;

        // IDLE ignores data requests
        In_Data_word = DW'(2790); In_Data_Ready = 1'b1;
        extra = 0;
        repeat (10) begin @(posedge aclk); #1; if (Decrypt_done || ready_to_encryption) extra++; end
        check("idle.ignore", extra, 0);
        @(negedge aclk); In_Data_Ready = 1'b0;

        // Key publication
        key_load();
        check("key.rdy", ready_to_encryption, 1);
        check("key.exp", Out_publicKey_exp, EK);
        check("key.mod", Out_publicKey_mod, NK);

        // Directed table
        for (int i = 0; i < 7; i++)
            do_vec($sformatf("vec%0d", i), vecs[i].c, vecs[i].m, (i == 0) ? 5 : 0);

        // Externally encrypted 101, twice, identical latency
        c101 = ref_pow(101, EK, NK);
        run_dec(DW'(c101), 0, m, lat1, pulses);
        check("m101a.data", m, 101);
        run_dec(DW'(c101), 0, m, lat2, pulses);
        check("m101b.data", m, 101);
        check("m101.lat_eq", lat2, lat1);

        // Randomized against the reference model
        for (int i = 0; i < 8; i++) begin
            if (i == 5) c = DW'($urandom_range(3233, 65535));
            else        c = DW'($urandom_range(0, 3232));
            do_vec($sformatf("rnd%0d", i), c, DW'(ref_dec(c)), i % 3);
        end

        // New_RSA_Start during BUSY is ignored
        fork
            run_dec(DW'(2790), 0, m, lat1, pulses);
            begin
                repeat (50) @(posedge aclk);
                @(negedge aclk); New_RSA_Start = 1'b1;
                @(negedge aclk); New_RSA_Start = 1'b0;
            end
        join
        check("busy_start.data", m, 65);
        check("busy_start.pulses", pulses, 1);
        check("busy_start.lat", lat1, lat_ref);
        check("busy_start.rdy", ready_to_encryption, 1);

        // Reset mid-BUSY aborts the operation
        @(negedge aclk); In_Data_word = DW'(855); In_Data_Ready = 1'b1;
        repeat (100) @(posedge aclk);
        #1;
        check("abort.busy_rdy", ready_to_encryption, 1);
        @(negedge aclk); aresetn = 1'b1; In_Data_Ready = 1'b0;
        @(posedge aclk); #1;
        check("abort.exp", Out_publicKey_exp, 0);
        check("abort.mod", Out_publicKey_mod, 0);
        check("abort.data", Out_Data_word, 0);
        check("abort.rdy", ready_to_encryption, 0);
        check("abort.done", Decrypt_done, 0);
        @(negedge aclk); aresetn = 1'b0;
        extra = 0;
        repeat (BOUND + 10) begin @(posedge aclk); #1; if (Decrypt_done) extra++; end
        check("abort.no_done", extra, 0);
        key_load();
        check("abort.reload_rdy", ready_to_encryption, 1);
        check("abort.reload_mod", Out_publicKey_mod, NK);
        do_vec("after_abort", DW'(2790), DW'(65), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rsa_decryption.md
RSA_DECRYPTION -- requirements
Module: rsa_decryption

Interface
REQ-001 Parameter WIDTH, default 512, base width; exponent ports are WIDTH bits, modulus and data ports are 4*WIDTH bits (DW).
REQ-002 Parameter KEY_N, default 3233, RSA modulus N, DW bits, odd, N > 2.
REQ-003 Parameter KEY_E, default 17, public exponent E, WIDTH bits.
REQ-004 Parameter KEY_D, default 2753, private exponent D, DW bits.
REQ-005 aclk  in  1  the single clock; all state updates occur on its rising edge.
REQ-006 aresetn  in  1  synchronous, active-high reset (1 = reset), despite the name.
REQ-007 In_Data_Ready  in  1  level request: In_Data_word holds valid ciphertext.
REQ-008 In_Data_word  in  DW  ciphertext C.
REQ-009 New_RSA_Start  in  1  single-cycle pulse requesting a key (re)load.
REQ-010 Out_publicKey_exp  out  WIDTH  public exponent E.
REQ-011 Out_publicKey_mod  out  DW  public modulus N.
REQ-012 ready_to_encryption  out  1  key is published and the block accepts ciphertext.
REQ-013 Out_Data_word  out  DW  plaintext M = C^D mod N.
REQ-014 Decrypt_done  out  1  one-cycle pulse: Out_Data_word is valid.

Function
REQ-015 The block SHALL implement the FSM states IDLE, KEYLOAD, READY, BUSY, DONE and WAIT_LOW.
REQ-016 IDLE: on New_RSA_Start=1, go to KEYLOAD; all other inputs are ignored.
REQ-017 KEYLOAD lasts one cycle: load E to Out_publicKey_exp and N to Out_publicKey_mod, then go to READY.
REQ-018 ready_to_encryption SHALL be 1 exactly in READY, BUSY, DONE and WAIT_LOW.
REQ-019 READY with New_RSA_Start=1 SHALL go to KEYLOAD; New_RSA_Start has priority over In_Data_Ready.
REQ-020 READY with In_Data_Ready=1 SHALL capture In_Data_word and go to BUSY; later changes to In_Data_word have no effect.
REQ-021 New_RSA_Start in BUSY, DONE or WAIT_LOW SHALL be ignored.
REQ-022 BUSY computes M = C^D mod N by LSB-first binary exponentiation over all DW bits of D.
- Per bit: result = result*base mod N when the bit is 1.
- Per bit: base = base*base mod N.
- Initial state: result = 1, base = C.
REQ-023 Modular multiply SHALL be bit-serial interleaved (shift-add with conditional subtraction of N), one multiplier bit per cycle, DW cycles per multiply. Both multiplies of an exponent step run concurrently.
REQ-024 Latency from the capture cycle to Decrypt_done SHALL be constant for a given WIDTH and SHALL NOT exceed DW*(DW+2)+4 cycles, independent of C and D.
REQ-025 If the captured C >= N, BUSY SHALL be skipped: Out_Data_word = 0 and Decrypt_done pulses the next cycle.
REQ-026 DONE lasts one cycle.
- Decrypt_done = 1 and Out_Data_word is updated.
- Then go to WAIT_LOW.
REQ-027 Out_Data_word SHALL hold its value until the next DONE or reset.
REQ-028 WAIT_LOW SHALL return to READY once In_Data_Ready = 0, so a held-high request is processed only once.
REQ-029 E = 0, D = 0 or C = 0 need no special handling; the required result follows the arithmetic (C^0 mod N = 1, 0^D mod N = 0 for D > 0).

Reset
REQ-030 While aresetn = 1 at a clock edge, the state SHALL become IDLE and all outputs 0: Out_publicKey_exp, Out_publicKey_mod, Out_Data_word, ready_to_encryption, Decrypt_done.
REQ-031 Reset during BUSY SHALL abort the operation; no Decrypt_done is produced for it.

Verification
REQ-032 Reset, then pulse New_RSA_Start -> two cycles later ready_to_encryption = 1, Out_publicKey_exp = 17, Out_publicKey_mod = 3233.
REQ-033 In_Data_word = 2790, In_Data_Ready held high until Decrypt_done -> Out_Data_word = 65, a single Decrypt_done pulse within the REQ-024 bound.
REQ-034 Encrypt 101 externally (101^17 mod 3233) and apply it -> Out_Data_word = 101; a second identical request gives identical latency.
REQ-035 In_Data_word = 4000 (>= N) -> Out_Data_word = 0, Decrypt_done on the cycle after capture.
REQ-036 Assert reset mid-BUSY -> all outputs 0 next cycle, no Decrypt_done; New_RSA_Start then restores READY.
REQ-037 New_RSA_Start pulsed during BUSY -> ignored, and the result is still correct.
